// File: rtl/decoder_pkg.sv
// Shared types and helpers for the one-hot decoder with autonomous scan mode.
package decoder_pkg;

    localparam int unsigned MAX_SEL_W = 6;
    localparam int unsigned MAX_OUT_W = 1 << MAX_SEL_W;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Full-width one-hot code; callers truncate to their own output width.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        return MAX_OUT_W'(1) << sel;
    endfunction

endpackage

// File: rtl/decoder_dwell_cnt.sv
// Scan index and dwell counter; step_c/wrap_c flag that the current step has expired.
module decoder_dwell_cnt #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               start,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   idx,
    output logic               step_c,
    output logic               wrap_c
);

    logic [DWELL_W-1:0] dwell_cnt;

    // Step is due when the hold count is exhausted; wrap when that step leaves the last index.
    assign step_c = (dwell_cnt == '0);
    assign wrap_c = step_c && (&idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            dwell_cnt <= '0;
        end else if (clear) begin
            idx       <= '0;
            dwell_cnt <= '0;
        end else if (start) begin
            idx       <= '0;
            dwell_cnt <= dwell;
        end else if (run) begin
            if (step_c) begin
                idx       <= idx + SEL_W'(1);
                dwell_cnt <= dwell;
            end else begin
                dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with enable, valid flag and a
// self-timed scan mode that walks the outputs with a programmable dwell.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DWELL_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       s,
    input  logic [DWELL_W-1:0]     dwell,
    output logic [(1<<SEL_W)-1:0]  y,
    output logic                   valid,
    output logic                   wrap
);

    localparam int unsigned OUT_W = 1 << SEL_W;

    state_t             state;
    state_t             state_nxt;
    logic [OUT_W-1:0]   y_nxt;
    logic               valid_nxt;
    logic               wrap_nxt;
    logic               clear_c;
    logic               start_c;
    logic               run_c;
    logic               step_c;
    logic               cnt_wrap_c;
    logic [SEL_W-1:0]   idx;
    logic [SEL_W-1:0]   idx_inc_c;

    assign idx_inc_c = idx + SEL_W'(1);

    decoder_dwell_cnt #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear_c),
        .start  (start_c),
        .run    (run_c),
        .dwell  (dwell),
        .idx    (idx),
        .step_c (step_c),
        .wrap_c (cnt_wrap_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next output code; scan bookkeeping is dropped whenever we leave SCAN.
    always_comb begin
        state_nxt = IDLE;
        y_nxt     = '0;
        valid_nxt = 1'b0;
        wrap_nxt  = 1'b0;
        clear_c   = 1'b1;
        start_c   = 1'b0;
        run_c     = 1'b0;
        if (en) begin
            case (mode)
                MODE_DIRECT: begin
                    state_nxt = DIRECT;
                    y_nxt     = OUT_W'(onehot(MAX_SEL_W'(s)));
                    valid_nxt = 1'b1;
                end
                MODE_SCAN: begin
                    state_nxt = SCAN;
                    valid_nxt = 1'b1;
                    clear_c   = 1'b0;
                    if (state != SCAN) begin
                        start_c = 1'b1;
                        y_nxt   = OUT_W'(1);
                    end else begin
                        run_c    = 1'b1;
                        wrap_nxt = cnt_wrap_c;
                        y_nxt    = step_c ? OUT_W'(onehot(MAX_SEL_W'(idx_inc_c))) : y;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y     <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            y     <= y_nxt;
            valid <= valid_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// Directed vector bench for decoder_scan: a 2-bit-select instance driven from a
// table, plus a 3-bit-select instance exercised with hand-written sequences.
module tb_decoder_scan;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // SEL_W=2 instance
    logic       rst_n, en, mode;
    logic [1:0] s;
    logic [3:0] dwell;
    logic [3:0] y;
    logic       valid, wrap;

    // SEL_W=3 instance
    logic       rst_n3, en3, mode3;
    logic [2:0] s3;
    logic [3:0] dwell3;
    logic [7:0] y3;
    logic       valid3, wrap3;

    int compared   = 0;
    int mismatched = 0;

    decoder_scan #(.SEL_W(2), .DWELL_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .dwell(dwell),
        .y(y), .valid(valid), .wrap(wrap)
    );

    decoder_scan #(.SEL_W(3), .DWELL_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n3), .en(en3), .mode(mode3), .s(s3), .dwell(dwell3),
        .y(y3), .valid(valid3), .wrap(wrap3)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       mode;
        logic [1:0] s;
        logic [3:0] dwell;
        logic [3:0] y;
        logic       valid;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic m,
                                input logic [1:0] sel, input logic [3:0] dw,
                                input logic [3:0] ey, input logic ev, input logic ew);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.s = sel; v.dwell = dw;
        v.y = ey; v.valid = ev; v.wrap = ew;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst_n3 = 1'b0; en3 = 1'b0; mode3 = 1'b0; s3 = '0; dwell3 = '0;

        //             rst en mode s    dwell  y        v  w
        // reset held with scan requested
        vecs.push_back(mk(0, 1, 1, 2'd0, 4'd0, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2'd0, 4'd0, 4'b0000, 0, 0));
        // direct decode
        vecs.push_back(mk(1, 1, 0, 2'd0, 4'd0, 4'b0001, 1, 0));
        vecs.push_back(mk(1, 1, 0, 2'd1, 4'd0, 4'b0010, 1, 0));
        vecs.push_back(mk(1, 1, 0, 2'd2, 4'd0, 4'b0100, 1, 0));
        vecs.push_back(mk(1, 1, 0, 2'd3, 4'd0, 4'b1000, 1, 0));
        // scan, dwell 0: entry has no wrap, return to 0001 does
        vecs.push_back(mk(1, 1, 1, 2'd3, 4'd0, 4'b0001, 1, 0));
        vecs.push_back(mk(1, 1, 1, 2'd3, 4'd0, 4'b0010, 1, 0));
        vecs.push_back(mk(1, 1, 1, 2'd3, 4'd0, 4'b0100, 1, 0));
        vecs.push_back(mk(1, 1, 1, 2'd3, 4'd0, 4'b1000, 1, 0));
        vecs.push_back(mk(1, 1, 1, 2'd3, 4'd0, 4'b0001, 1, 1));
        vecs.push_back(mk(1, 1, 1, 2'd3, 4'd0, 4'b0010, 1, 0));
        vecs.push_back(mk(1, 0, 1, 2'd3, 4'd0, 4'b0000, 0, 0));
        // scan, dwell 2: each code held 3 cycles, 12-cycle sweep
        for (int k = 0; k < 12; k++)
            vecs.push_back(mk(1, 1, 1, 2'd0, 4'd2, 4'(4'b0001 << (k / 3)), 1, 0));
        vecs.push_back(mk(1, 1, 1, 2'd0, 4'd2, 4'b0001, 1, 1));
        // dwell drops to 0 mid-hold: old hold finishes, new dwell from next reload
        vecs.push_back(mk(1, 1, 1, 2'd0, 4'd0, 4'b0001, 1, 0));
        vecs.push_back(mk(1, 1, 1, 2'd0, 4'd0, 4'b0001, 1, 0));
        vecs.push_back(mk(1, 1, 1, 2'd0, 4'd0, 4'b0010, 1, 0));
        vecs.push_back(mk(1, 1, 1, 2'd0, 4'd0, 4'b0100, 1, 0));
        // mode->0 while 0100: direct decode of s=2
        vecs.push_back(mk(1, 1, 0, 2'd2, 4'd0, 4'b0100, 1, 0));
        // back to scan restarts at index 0
        vecs.push_back(mk(1, 1, 1, 2'd2, 4'd0, 4'b0001, 1, 0));
        vecs.push_back(mk(1, 1, 1, 2'd2, 4'd0, 4'b0010, 1, 0));
        vecs.push_back(mk(1, 1, 1, 2'd2, 4'd0, 4'b0100, 1, 0));
        vecs.push_back(mk(1, 1, 1, 2'd2, 4'd0, 4'b1000, 1, 0));
        // en->0 while a wrap step is due: no pulse
        vecs.push_back(mk(1, 0, 1, 2'd2, 4'd0, 4'b0000, 0, 0));
        // mid-scan reset, then re-entry from idle
        vecs.push_back(mk(1, 1, 1, 2'd2, 4'd0, 4'b0001, 1, 0));
        vecs.push_back(mk(1, 1, 1, 2'd2, 4'd0, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 1, 1, 2'd2, 4'd0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, 1, 1, 2'd2, 4'd0, 4'b0001, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n; en = vecs[i].en; mode = vecs[i].mode;
            s = vecs[i].s; dwell = vecs[i].dwell;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.y", i), 64'(y), 64'(vecs[i].y));
            check($sformatf("vec%0d.valid", i), 64'(valid), 64'(vecs[i].valid));
            check($sformatf("vec%0d.wrap", i), 64'(wrap), 64'(vecs[i].wrap));
        end
        en = 1'b0;

        // SEL_W=3: reset, then direct decode across all eight selects
        @(posedge clk); #1;
        check("w3.reset.y", 64'(y3), 64'(0));
        check("w3.reset.valid", 64'(valid3), 64'(0));
        rst_n3 = 1'b1; en3 = 1'b1; mode3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e;
            e = 8'd1 << i;
            s3 = 3'(i);
            @(posedge clk); #1;
            check($sformatf("w3.direct%0d.y", i), 64'(y3), 64'(e));
            check($sformatf("w3.direct%0d.valid", i), 64'(valid3), 64'(1));
        end

        // SEL_W=3 scan with dwell 1: index = k/2, wrap every 16 cycles after entry
        mode3 = 1'b1; dwell3 = 4'd1;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] e;
            e = 8'd1 << ((k / 2) % 8);
            @(posedge clk); #1;
            check($sformatf("w3.scan%0d.y", k), 64'(y3), 64'(e));
            check($sformatf("w3.scan%0d.wrap", k), 64'(wrap3), 64'((k > 0) && (k % 16 == 0)));
            check($sformatf("w3.scan%0d.onehot", k), 64'(valid3 && $onehot(y3)), 64'(1));
        end
        en3 = 1'b0;
        @(posedge clk); #1;
        check("w3.off.y", 64'(y3), 64'(0));
        check("w3.off.valid", 64'(valid3), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
